// File: rtl/nw_rx_fifo.sv
// nw_rx_fifo: first-word-fall-through receive buffer for network words feeding
// the register-file stage. The head word is always visible on fifoindata, so a
// pop consumes the word that is on the bus in the same cycle.
// Optional build macro NWFIFO_ERRFLAG_EN adds the sticky nwovf/nwunf outputs.
module nw_rx_fifo #(
  parameter int WIDTH      = 1048,
  parameter int DEPTH_LOG2 = 2,
  parameter int AFULL_TH   = 3
) (
  input  logic                  clk,
  input  logic                  NWFIFOclear_n,
  input  logic                  nwflush,
  input  logic                  nwin_valid,
  output logic                  nwin_ready,
  input  logic [WIDTH-1:0]      nwin_data,
  input  logic                  fiforeaden,
  input  logic                  RFREGstall,
  output logic [WIDTH-1:0]      fifoindata,
  output logic                  nwempty_stall,
  output logic [DEPTH_LOG2:0]   nwcount,
  output logic                  nwafull
`ifdef NWFIFO_ERRFLAG_EN
  ,
  output logic                  nwovf,
  output logic                  nwunf
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] ptr_t;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  ptr_t wr_ptr, rd_ptr;
  logic empty, full, push, pop;

  // MSB is the wrap bit: equal pointers mean empty, same slot on opposite laps means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                 (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);

  // No lookahead: a full buffer refuses a write even if a pop frees a slot this cycle.
  assign nwin_ready    = !full;
  assign push          = nwin_valid && nwin_ready;
  assign pop           = fiforeaden && !RFREGstall && !empty;
  assign nwempty_stall = fiforeaden && empty;

  // Pointer difference is exact across wrap because of the extra wrap bit.
  assign nwcount    = wr_ptr - rd_ptr;
  assign nwafull    = (nwcount >= ptr_t'(AFULL_TH));
  assign fifoindata = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge NWFIFOclear_n) begin
    if (!NWFIFOclear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (nwflush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // Storage is not reset; a write landing during reset or flush is unreachable
  // because the pointers return to zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= nwin_data;
  end

`ifdef NWFIFO_ERRFLAG_EN
  logic [3:0] unf_cnt;

  // Sticky error flags; nwunf fires on the 16th consecutive empty-load cycle.
  always_ff @(posedge clk or negedge NWFIFOclear_n) begin
    if (!NWFIFOclear_n) begin
      nwovf   <= 1'b0;
      nwunf   <= 1'b0;
      unf_cnt <= '0;
    end else if (nwflush) begin
      nwovf   <= 1'b0;
      nwunf   <= 1'b0;
      unf_cnt <= '0;
    end else begin
      if (nwin_valid && full) nwovf <= 1'b1;
      if (nwempty_stall) begin
        if (unf_cnt == 4'hF) nwunf   <= 1'b1;
        else                 unf_cnt <= unf_cnt + 4'd1;
      end else begin
        unf_cnt <= '0;
      end
    end
  end
`endif

endmodule
